// File: rtl/bus_wait_pkg.sv
// Shared types and constants for the bus_wait_ctrl wait-state controller.
// Optional stall counter in the top is enabled by BUS_WAIT_CTRL_PERF_EN.
package bus_wait_pkg;

  localparam int unsigned BUS_WAIT_ADDR_MAX  = 32;
  localparam int unsigned BUS_WAIT_DATA_MAX  = 32;
  localparam int unsigned BUS_WAIT_IDX_W     = 3;
  localparam int unsigned BUS_WAIT_CNT_W_DEF = 4;
  localparam int unsigned BUS_WAIT_CNT_MAX   = (1 << BUS_WAIT_CNT_W_DEF) - 1;

  typedef enum logic {
    ACCESS = 1'b0,
    WAIT   = 1'b1
  } bus_wait_state_t;

  // Sized for the widest supported bus; instances use the low ADDR_W/DATA_W bits.
  typedef struct packed {
    logic [BUS_WAIT_ADDR_MAX-1:0] addr;
    logic [BUS_WAIT_DATA_MAX-1:0] wdata;
    logic                         we;
  } bus_wait_req_t;

  function automatic int unsigned bus_wait_cnt_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/bus_wait_decode.sv
// Combinational priority region decoder: lowest matching region index wins,
// no match yields DEFAULT_WAIT (saturated to the counter width).
module bus_wait_decode
  import bus_wait_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned NUM_REGIONS  = 4,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned DEFAULT_WAIT = 0
) (
  input  logic [ADDR_W-1:0]             ab,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_mask,
  input  logic [NUM_REGIONS*CNT_W-1:0]  cfg_wait,
  output logic [BUS_WAIT_IDX_W-1:0]     idx,
  output logic                          hit,
  output logic [CNT_W-1:0]              wait_n
);

  localparam int unsigned DEF_SAT = (DEFAULT_WAIT > bus_wait_cnt_max(CNT_W)) ?
                                    bus_wait_cnt_max(CNT_W) : DEFAULT_WAIT;
  localparam logic [CNT_W-1:0] DEF_WAIT = CNT_W'(DEF_SAT);

  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    wait_n = DEF_WAIT;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!hit && ((ab & cfg_mask[i*ADDR_W +: ADDR_W]) ==
                   (cfg_base[i*ADDR_W +: ADDR_W] & cfg_mask[i*ADDR_W +: ADDR_W]))) begin
        hit    = 1'b1;
        idx    = BUS_WAIT_IDX_W'(i);
        wait_n = cfg_wait[i*CNT_W +: CNT_W];
      end
    end
  end

endmodule

// File: rtl/bus_wait_ctrl.sv
// Wait-state controller between a 6502-style CPU and a one-cycle-latency RAM.
// Define BUS_WAIT_CTRL_PERF_EN to implement the stall_cycles counter.
module bus_wait_ctrl
  import bus_wait_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned NUM_REGIONS  = 4,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned DEFAULT_WAIT = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             ab,
  input  logic [DATA_W-1:0]             dout,
  input  logic                          we,
  output logic [DATA_W-1:0]             di,
  output logic                          rdy,
  input  logic                          ext_stall,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_mask,
  input  logic [NUM_REGIONS*CNT_W-1:0]  cfg_wait,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [31:0]                   stall_cycles
);

  bus_wait_state_t             state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            dec_wait;
  logic [BUS_WAIT_IDX_W-1:0]   unused_dec_idx;
  logic                        unused_dec_hit;
  logic                        unused_req_hi;
  bus_wait_req_t               req_q;
  logic                        strobe_q;
  logic [DATA_W-1:0]           hold_q;

  bus_wait_decode #(
    .ADDR_W       (ADDR_W),
    .NUM_REGIONS  (NUM_REGIONS),
    .CNT_W        (CNT_W),
    .DEFAULT_WAIT (DEFAULT_WAIT)
  ) u_decode (
    .ab       (ab),
    .cfg_base (cfg_base),
    .cfg_mask (cfg_mask),
    .cfg_wait (cfg_wait),
    .idx      (unused_dec_idx),
    .hit      (unused_dec_hit),
    .wait_n   (dec_wait)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCESS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACCESS: begin
        if (dec_wait != '0 || ext_stall) begin
          state_d = WAIT;
          cnt_d   = (dec_wait == '0) ? '0 : dec_wait - CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!ext_stall) begin
          state_d = ACCESS;
        end
      end
      default: state_d = ACCESS;
    endcase
  end

  // Zero-wait accesses strobe straight from the live bus; delayed ones replay
  // the request captured in the address cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ab;
    mem_wdata = dout;
    if (state_q == ACCESS) begin
      mem_en = !reset && (dec_wait == '0) && !ext_stall;
      mem_we = mem_en && we;
    end else begin
      mem_addr  = req_q.addr[ADDR_W-1:0];
      mem_wdata = req_q.wdata[DATA_W-1:0];
      mem_en    = !reset && (cnt_q == '0) && !ext_stall;
      mem_we    = mem_en && req_q.we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
    end else if (state_q == ACCESS) begin
      req_q <= '{addr:  BUS_WAIT_ADDR_MAX'(ab),
                 wdata: BUS_WAIT_DATA_MAX'(dout),
                 we:    we};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      strobe_q <= mem_en;
      if (strobe_q) begin
        hold_q <= mem_rdata;
      end
    end
  end

  assign unused_req_hi = ^{req_q.addr, req_q.wdata};
  assign rdy           = (state_q == ACCESS);
  assign di            = (state_q == ACCESS) ? mem_rdata : hold_q;

`ifdef BUS_WAIT_CTRL_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == WAIT) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
